sha_round_stage: RTL
====================

Name: sha_round_stage

Overview:
- SHA-256 compression stage that sits directly downstream of the message-schedule stage.
- Consumes a window of ROUNDS schedule words plus a working state a..h, and runs ROUNDS compression rounds, one per clock.
- Emits the updated working state with a one-cycle en_next pulse to the next round stage or the digest sink.
- Carries the chaining value H through unchanged; when FINAL_ADD=1 it adds H to the working state on completion.

Parameters:
- ROUNDS, 16, rounds executed per invocation (1..64); sets Win width to ROUNDS*32.
- ROUND_BASE, 0, global index of the first round; K constant used in local round r is K[ROUND_BASE+r]. ROUND_BASE+ROUNDS must be <= 64.
- FINAL_ADD, 0, 1 = Sout is the per-word mod-2^32 sum of the final working state and the captured Hin.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  start pulse; Win/Sin/Hin are valid in the same cycle
- Win  input  ROUNDS*32  schedule words; bits [r*32+:32] = W[ROUND_BASE+r]
- Sin  input  256  working state; a=[255:224], b=[223:192], ..., h=[31:0]
- Hin  input  256  chaining value, same packing as Sin
- Sout  output  256  working state after ROUNDS rounds (plus Hin if FINAL_ADD)
- Hout  output  256  Hin captured at start
- busy  output  1  high while rounds are in progress
- en_next  output  1  one-cycle pulse; Sout/Hout are valid from this cycle until the next start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cnt=0; Sout=0, Hout=0, busy=0, en_next=0; internal registers cleared. Deassertion is sampled synchronously.
- FSM states: IDLE, RUN, DONE.
- IDLE, en=1: capture Win into wbuf, Sin into the work registers, Hin into the H register; cnt<=0; go to RUN; busy<=1.
- RUN, each cycle: perform one round on the work registers using W=wbuf[cnt] and K=K_ROM[ROUND_BASE+cnt].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K + W
  - T2 = Σ0(a) + Maj(a,b,c)
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
  - All additions are 32-bit mod 2^32; carries are discarded.
  - Σ0=ROTR2^ROTR13^ROTR22; Σ1=ROTR6^ROTR11^ROTR25; Ch=(e&f)^(~e&g); Maj=(a&b)^(a&c)^(b&c).
- End of RUN: on the cycle cnt==ROUNDS-1, after the round, cnt<=0 and go to DONE.
- DONE (one cycle):
  - Sout <= work (or work+H per word if FINAL_ADD); Hout <= H; en_next <= 1; busy <= 0; return to IDLE.
- Latency: en sampled at edge N → en_next high in the cycle after edge N+ROUNDS+1, i.e. ROUNDS+2 cycles after start.
- Throughput: one block per ROUNDS+2 cycles.
- en while busy (RUN or DONE): ignored, no capture. en in the same cycle en_next is high is accepted, since the FSM is already back in IDLE.
- en_next is high for exactly one cycle per accepted start; it is 0 in all other cycles.
- Sout/Hout hold their last values while IDLE and while RUN, and change only in DONE.
- K ROM: the standard 64 SHA-256 constants (K[0]=0x428a2f98, K[63]=0xc67178f2), synthesized as combinational ROM.
- ROUNDS=1 is legal: exactly one RUN cycle, then DONE.
- Reset asserted mid-RUN aborts the operation: outputs return to reset values and en_next never pulses for the aborted block.

Test Plan:
- Single round, ROUNDS=1, ROUND_BASE=0: Sin=SHA-256 IV (6a09e667 … 5be0cd19), W0=0x61626380 ("abc") → Sout a=5D6AEBCD, b=6A09E667, c=BB67AE85, d=3C6EF372, e=FA2A4622, f=510E527F, g=9B05688C, h=1F83D9AB; en_next 3 cycles after en.
- Full block, ROUNDS=64, FINAL_ADD=1: padded-"abc" schedule W0..W63, Sin=Hin=IV → Sout=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; Hout=IV; en_next exactly 66 cycles after en.
- Chain of four stages (ROUNDS=16, ROUND_BASE=0/16/32/48, last with FINAL_ADD=1), driven with the "abc" vectors → final Sout equals the digest above.
- en pulsed every cycle for 20 cycles, ROUNDS=16 → exactly two starts accepted (cycles 0 and 18), exactly two en_next pulses; busy high 17 cycles per block.
- Reset driven low at RUN cycle 5, then released → busy=0, Sout=0, no en_next; a fresh start then yields the correct result.
- Back-to-back operation: en asserted in the en_next cycle with new data → previous Sout is held until the new DONE, and the second result is correct.

Source files
------------

// File: rtl/sha_round_stage.sv
// SHA-256 compression stage: runs ROUNDS rounds, one per clock, on a captured
// working state and schedule window, then publishes the result with en_next.
module sha_round_stage #(
   parameter int ROUNDS     = 16,
   parameter int ROUND_BASE = 0,
   parameter bit FINAL_ADD  = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [ROUNDS*32-1:0] Win,
   input  logic [255:0]         Sin,
   input  logic [255:0]         Hin,
   output logic [255:0]         Sout,
   output logic [255:0]         Hout,
   output logic                 busy,
   output logic                 en_next
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 1);
   localparam logic [5:0] BASE_IDX = 6'(ROUND_BASE);

   localparam logic [31:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   state_t               state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [ROUNDS*32-1:0] wbuf_q, wbuf_d;
   logic [255:0]         work_q, work_d;
   logic [255:0]         chain_q, chain_d;
   logic [255:0]         sout_q, sout_d;
   logic [255:0]         hout_q, hout_d;
   logic                 busy_q, busy_d;
   logic                 enNext_q, enNext_d;

   logic [5:0]           kIdx;
   logic [255:0]         roundOut;
   logic [255:0]         finalSum;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] shaRound(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
      logic [31:0] a, b, c, d, e, f, g, h;
      logic [31:0] bigS0, bigS1, ch, maj, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      bigS1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      ch    = (e & f) ^ (~e & g);
      t1    = h + bigS1 + ch + k + w;
      bigS0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      maj   = (a & b) ^ (a & c) ^ (b & c);
      t2    = bigS0 + maj;
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   // The window is consumed from the low end, so the current W is always
   // the bottom word and no wide read mux is needed.
   assign kIdx     = BASE_IDX + cnt_q;
   assign roundOut = shaRound(work_q, K_ROM[kIdx], wbuf_q[31:0]);

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         finalSum[i*32 +: 32] = work_q[i*32 +: 32] + chain_q[i*32 +: 32];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wbuf_d   = wbuf_q;
      work_d   = work_q;
      chain_d  = chain_q;
      sout_d   = sout_q;
      hout_d   = hout_q;
      busy_d   = busy_q;
      enNext_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               wbuf_d  = Win;
               work_d  = Sin;
               chain_d = Hin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d = roundOut;
            wbuf_d = wbuf_q >> 32;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         DONE: begin
            sout_d   = FINAL_ADD ? finalSum : work_q;
            hout_d   = chain_q;
            enNext_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wbuf_q   <= '0;
         work_q   <= '0;
         chain_q  <= '0;
         sout_q   <= '0;
         hout_q   <= '0;
         busy_q   <= 1'b0;
         enNext_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wbuf_q   <= wbuf_d;
         work_q   <= work_d;
         chain_q  <= chain_d;
         sout_q   <= sout_d;
         hout_q   <= hout_d;
         busy_q   <= busy_d;
         enNext_q <= enNext_d;
      end
   end

   assign Sout    = sout_q;
   assign Hout    = hout_q;
   assign busy    = busy_q;
   assign en_next = enNext_q;

endmodule
